// File: rtl/sim_tb_cmd_responder.sv
// Purpose: executes one tagged interpreter command (ping, bus write/read, run-N gate) and returns one tagged response.
// Latency: PING 1 cycle; bus access k+1 cycles (ack in BUS cycle k, at most TIMEOUT); RUN N takes N+1 cycles.
// Backpressure: single command in flight; cmd_ready stays low until the response is taken with rsp_ready.
module sim_tb_cmd_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              run_en,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RUN  = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    localparam logic [1:0]  OP_PING   = 2'd0;
    localparam logic [1:0]  OP_WRITE  = 2'd1;
    localparam logic [1:0]  OP_READ   = 2'd2;
    localparam logic [1:0]  OP_RUN    = 2'd3;
    localparam logic [1:0]  ST_OK     = 2'd0;
    localparam logic [1:0]  ST_TMO    = 2'd1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_wait;
    logic [DATA_W-1:0]   r_run_cnt;

    logic                r_cmd_ready;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_run_en;
    logic                r_rsp_valid;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [1:0]          r_rsp_status;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_accept;
    logic                w_is_write;
    logic                w_rsp_load;
    logic [TAG_W-1:0]    w_rsp_tag;
    logic [1:0]          w_rsp_status;
    logic [DATA_W-1:0]   w_rsp_data;

    // r_cmd_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_is_write = w_accept ? (cmd_op == OP_WRITE) : (r_op == OP_WRITE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_rsp_load   = 1'b0;
        w_rsp_tag    = r_tag;
        w_rsp_status = ST_OK;
        w_rsp_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_rsp_tag = cmd_tag;
                    case (cmd_op)
                        OP_PING: begin
                            w_next     = S_RSP;
                            w_rsp_load = 1'b1;
                            w_rsp_data = cmd_data;
                        end
                        OP_WRITE, OP_READ: begin
                            w_next = S_BUS;
                        end
                        default: begin
                            if (cmd_data != '0) begin
                                w_next = S_RUN;
                            end else begin
                                w_next     = S_RSP;
                                w_rsp_load = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_BUS: begin
                // An ack on the last permitted cycle wins over the timeout.
                if (bus_ack) begin
                    w_next     = S_RSP;
                    w_rsp_load = 1'b1;
                    w_rsp_data = (r_op == OP_READ) ? bus_rdata : '0;
                end else if (r_wait == WAIT_LAST) begin
                    w_next       = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_status = ST_TMO;
                end
            end
            S_RUN: begin
                if (r_run_cnt == DATA_W'(1)) begin
                    w_next     = S_RSP;
                    w_rsp_load = 1'b1;
                    w_rsp_data = r_data;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op        <= OP_PING;
            r_tag       <= '0;
            r_data      <= '0;
            r_wait      <= '0;
            r_run_cnt   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_accept) begin
            r_op      <= cmd_op;
            r_tag     <= cmd_tag;
            r_data    <= cmd_data;
            r_wait    <= '0;
            r_run_cnt <= cmd_data;
            if (cmd_op == OP_WRITE || cmd_op == OP_READ) begin
                r_bus_addr  <= cmd_addr;
                r_bus_wdata <= (cmd_op == OP_WRITE) ? cmd_data : '0;
            end
        end else begin
            if (r_state == S_BUS && !bus_ack) begin
                r_wait <= r_wait + 16'd1;
            end
            if (r_state == S_RUN) begin
                r_run_cnt <= r_run_cnt - DATA_W'(1);
            end
        end
    end

    // Control outputs are registered copies of the next state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cmd_ready  <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_run_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_status <= ST_OK;
            r_rsp_data   <= '0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_bus_req   <= (w_next == S_BUS);
            r_bus_we    <= (w_next == S_BUS) && w_is_write;
            r_run_en    <= (w_next == S_RUN);
            r_rsp_valid <= (w_next == S_RSP);
            if (w_rsp_load) begin
                r_rsp_tag    <= w_rsp_tag;
                r_rsp_status <= w_rsp_status;
                r_rsp_data   <= w_rsp_data;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign run_en     = r_run_en;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_status = r_rsp_status;
    assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_sim_tb_cmd_responder.sv
// Directed bench for sim_tb_cmd_responder with TIMEOUT=4 and hand-computed expectations.
module tb_sim_tb_cmd_responder;

    localparam logic [1:0] OP_PING  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    logic        CLK;
    logic        RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_tag;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        run_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_tag;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    sim_tb_cmd_responder #(
        .ADDR_W(16), .DATA_W(32), .TAG_W(8), .TIMEOUT(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_tag(cmd_tag), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .run_en(run_en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag), .rsp_status(rsp_status), .rsp_data(rsp_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check($sformatf("%s.cmd_ready_wait", nm), cmd_ready, 1'b1);
    endtask

    // Issues one command with rsp_ready high, plays the bus target (ack in BUS cycle ack_k, 0 = never)
    // and checks the response, the cycle counts and the latency from the accept edge.
    task automatic run_cmd(input string nm, input logic [1:0] op, input logic [7:0] tag,
                           input logic [15:0] addr, input logic [31:0] data,
                           input int ack_k, input logic [31:0] rdata,
                           input logic [1:0] exp_st, input logic [31:0] exp_dat,
                           input int exp_req, input int exp_run, input int exp_lat);
        int   req_cyc = 0;
        int   run_cyc = 0;
        int   lat     = 1;
        logic got     = 1'b0;
        logic seen_we = 1'b0;
        logic stable  = 1'b1;
        logic [7:0]  o_tag = '0;
        logic [1:0]  o_st  = '0;
        logic [31:0] o_dat = '0;
        wait_ready(nm);
        cmd_valid = 1'b1; cmd_op = op; cmd_tag = tag; cmd_addr = addr; cmd_data = data;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1; o_tag = rsp_tag; o_st = rsp_status; o_dat = rsp_data;
            end else begin
                if (bus_req) begin
                    req_cyc++;
                    seen_we = bus_we;
                    if (bus_addr !== addr || (op == OP_WRITE && bus_wdata !== data)) stable = 1'b0;
                end
                if (run_en) run_cyc++;
                bus_ack   = bus_req && (req_cyc == ack_k);
                bus_rdata = rdata;
                tick();
                lat++;
            end
        end
        bus_ack = 1'b0;
        check($sformatf("%s.rsp_seen", nm), got, 1'b1);
        check($sformatf("%s.tag", nm), o_tag, tag);
        check($sformatf("%s.status", nm), o_st, exp_st);
        check($sformatf("%s.data", nm), o_dat, exp_dat);
        check($sformatf("%s.req_cycles", nm), req_cyc, exp_req);
        check($sformatf("%s.run_cycles", nm), run_cyc, exp_run);
        check($sformatf("%s.latency", nm), lat, exp_lat);
        check($sformatf("%s.bus_we", nm), seen_we, (op == OP_WRITE));
        check($sformatf("%s.bus_stable", nm), stable, 1'b1);
        tick();
        check($sformatf("%s.rsp_once", nm), rsp_valid, 1'b0);
        check($sformatf("%s.ready_after", nm), cmd_ready, 1'b1);
    endtask

    initial begin
        RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_tag = '0; cmd_addr = '0;
        cmd_data = '0; bus_ack = 1'b0; bus_rdata = '0; rsp_ready = 1'b0;

        // Reset and release
        repeat (3) tick();
        check("reset.ctrl", {cmd_ready, bus_req, bus_we, run_en, rsp_valid}, 5'd0);
        check("reset.fields", {bus_addr, rsp_tag, rsp_status}, 26'd0);
        check("reset.wdata", bus_wdata, 32'd0);
        check("reset.rsp_data", rsp_data, 32'd0);
        RST_N = 1'b1;
        check("release.ready_low", cmd_ready, 1'b0);
        tick();
        check("release.ready_high", cmd_ready, 1'b1);

        // Ping held under backpressure for 5 cycles
        cmd_valid = 1'b1; cmd_op = OP_PING; cmd_tag = 8'h5A; cmd_data = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ping_bp.valid%0d", i), rsp_valid, 1'b1);
            check($sformatf("ping_bp.rsp%0d", i), {rsp_tag, rsp_status, rsp_data},
                  {8'h5A, 2'd0, 32'hDEADBEEF});
            check($sformatf("ping_bp.ready%0d", i), cmd_ready, 1'b0);
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("ping_bp.valid_drop", rsp_valid, 1'b0);
        check("ping_bp.ready_back", cmd_ready, 1'b1);

        // Write then read, timeouts, run gate
        run_cmd("write",  OP_WRITE, 8'h11, 16'h0010, 32'h12345678, 3, 32'h0,
                2'd0, 32'h0, 3, 0, 4);
        run_cmd("read",   OP_READ,  8'h12, 16'h0010, 32'h0, 1, 32'h12345678,
                2'd0, 32'h12345678, 1, 0, 2);
        run_cmd("tmo",    OP_READ,  8'h13, 16'h0020, 32'h0, 0, 32'h55AA55AA,
                2'd1, 32'h0, 4, 0, 5);
        run_cmd("tmo_ok", OP_READ,  8'h14, 16'h0020, 32'h0, 4, 32'hCAFEF00D,
                2'd0, 32'hCAFEF00D, 4, 0, 5);

        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (3) tick();
        check("stray_ack.idle", {bus_req, rsp_valid, run_en, cmd_ready}, 4'b0001);
        bus_ack = 1'b0;
        run_cmd("after_stray", OP_PING, 8'h15, 16'h0, 32'h00000042, 0, 32'h0,
                2'd0, 32'h42, 0, 0, 1);

        run_cmd("run5", OP_RUN, 8'h16, 16'h0, 32'd5, 0, 32'h0, 2'd0, 32'd5, 0, 5, 6);
        run_cmd("run0", OP_RUN, 8'h17, 16'h0, 32'd0, 0, 32'h0, 2'd0, 32'd0, 0, 0, 1);

        // Back-to-back mixed commands
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op;
            logic [15:0] addr;
            logic [31:0] data, rdata;
            int          k;
            op    = 2'($urandom_range(0, 3));
            addr  = 16'($urandom);
            data  = $urandom;
            rdata = $urandom;
            k     = $urandom_range(1, 3);
            case (op)
                OP_PING:  run_cmd($sformatf("b2b%0d", i), op, 8'(8'h80 + i), addr, data, k, rdata,
                                  2'd0, data, 0, 0, 1);
                OP_WRITE: run_cmd($sformatf("b2b%0d", i), op, 8'(8'h80 + i), addr, data, k, rdata,
                                  2'd0, 32'h0, k, 0, k + 1);
                OP_READ:  run_cmd($sformatf("b2b%0d", i), op, 8'(8'h80 + i), addr, data, k, rdata,
                                  2'd0, rdata, k, 0, k + 1);
                default: begin
                    data = 32'($urandom_range(0, 3));
                    run_cmd($sformatf("b2b%0d", i), op, 8'(8'h80 + i), addr, data, k, rdata,
                            2'd0, data, 0, int'(data), int'(data) + 1);
                end
            endcase
        end

        // Asynchronous reset in the middle of a bus access
        wait_ready("rst_mid");
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_tag = 8'h99; cmd_addr = 16'h0030;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_mid.req_before", bus_req, 1'b1);
        #3 RST_N = 1'b0;
        #1;
        check("rst_mid.req_dropped", bus_req, 1'b0);
        check("rst_mid.ready_low", cmd_ready, 1'b0);
        tick();
        tick();
        RST_N = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (rsp_valid) seen++;
            end
            check("rst_mid.no_rsp", seen, 0);
        end
        check("rst_mid.ready", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_tb_cmd_responder.md
# sim_tb_cmd_responder

Design-side responder for the simulation testbench interpreter. It accepts tagged commands from the interpreter bridge over a valid/ready channel and executes each one. Commands are a ping, a single register write or read on a simple request/acknowledge target bus, or a "run N cycles" gate. Each command returns exactly one tagged response, with a timeout status if the target bus never acknowledges.

## Interface
Parameters:
- ADDR_W, 16, target bus address width
- DATA_W, 32, command/bus/response data width; also the run-count width
- TAG_W, 8, command/response tag width
- TIMEOUT, 255, maximum bus_req cycles per access; legal range 1..65535

Ports (one clock `CLK`; reset `RST_N` is asynchronous and active-low):
- CLK  input  1  clock, all state on posedge
- RST_N  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  responder can accept a command
- cmd_op  input  2  0=PING, 1=WRITE, 2=READ, 3=RUN
- cmd_tag  input  TAG_W  echoed in the response
- cmd_addr  input  ADDR_W  bus address (WRITE/READ)
- cmd_data  input  DATA_W  write data (WRITE), echo value (PING), cycle count (RUN)
- bus_req  output  1  bus access request
- bus_we  output  1  1=write, 0=read
- bus_addr  output  ADDR_W  access address
- bus_wdata  output  DATA_W  write data
- bus_ack  input  1  target completes the access this cycle
- bus_rdata  input  DATA_W  read data, valid with bus_ack
- run_en  output  1  design run gate
- rsp_valid  output  1  response present
- rsp_ready  input  1  bridge takes the response
- rsp_tag  output  TAG_W  tag of the completed command
- rsp_status  output  2  0=OK, 1=TIMEOUT (2 and 3 never driven)
- rsp_data  output  DATA_W  result data

## Operation
- FSM states: IDLE, BUS, RUN, RSP. Exactly one command is in flight; there is no queueing.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, tag, addr and data.
  - PING goes to RSP with rsp_data=cmd_data and status OK.
  - WRITE or READ goes to BUS.
  - RUN goes to RUN when cmd_data≠0. When cmd_data=0 it goes straight to RSP, with status OK and rsp_data=0.
- BUS:
  - bus_req=1.
  - bus_we is 1 for WRITE.
  - bus_addr and bus_wdata come from the latched command and are stable for the whole access.
  - A 16-bit wait counter clears on entry and increments on every BUS cycle without bus_ack.
  - On bus_ack, go to RSP with status OK. rsp_data is bus_rdata for READ and 0 for WRITE.
  - If bus_ack is low and the counter equals TIMEOUT-1, go to RSP with status TIMEOUT and rsp_data=0.
  - bus_req is therefore high for at most TIMEOUT cycles.
  - If bus_ack arrives on the last permitted cycle, the access succeeds.
- RUN:
  - run_en=1.
  - A DATA_W down-counter is loaded with N on accept and decrements each RUN cycle.
  - On the cycle it reads 1, go to RSP with status OK and rsp_data=N.
  - run_en is therefore high for exactly N cycles.
- RSP:
  - rsp_valid=1; rsp_tag, rsp_status and rsp_data are held stable.
  - On rsp_ready, return to IDLE.
- bus_ack is ignored in any state other than BUS; a late ack after a timeout has no effect.
- All outputs are registered.

## Timing
- Reset (RST_N low, asynchronous):
  - State goes to IDLE.
  - cmd_ready=0, bus_req=0, bus_we=0, run_en=0, rsp_valid=0.
  - bus_addr, bus_wdata, rsp_tag, rsp_status, rsp_data and the counters are all 0.
  - cmd_ready rises on the first posedge after RST_N deasserts.
- Reset mid-operation aborts the command; no response is ever produced for it.
- cmd_ready falls in the cycle after an accept and rises again in the cycle after the rsp handshake. The minimum spacing between accepts is therefore 2 cycles for PING with rsp_ready held high.
- Latency is measured from the accept edge A:
  - PING: rsp_valid at A+1.
  - WRITE/READ: bus_req at A+1. With bus_ack in BUS cycle k (1-based), bus_req falls and rsp_valid rises at A+k+1.
  - Timeout: bus_req is high for cycles A+1..A+TIMEOUT, and rsp_valid rises at A+TIMEOUT+1.
  - RUN N: run_en high for A+1..A+N, rsp_valid at A+N+1.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: hold RST_N low for 3 cycles, then release. All outputs are 0 during reset. cmd_ready=1 one cycle after release. Assert RST_N asynchronously mid-BUS: bus_req drops immediately and no response follows.
- Ping with backpressure: send PING with tag=0x5A and data=0xDEADBEEF, holding rsp_ready low for 4 cycles. rsp_valid rises at A+1 and holds stable for 5 cycles with tag 0x5A, status 0 and data 0xDEADBEEF. cmd_ready stays 0 until the handshake.
- Write then read:
  - WRITE addr=0x0010, data=0x12345678, with bus_ack on BUS cycle 3. bus_req/bus_we high for 3 cycles, then response status 0 with data 0.
  - READ addr=0x0010, bus_ack with rdata=0x12345678 on BUS cycle 1. rsp_data=0x12345678.
- Timeout with TIMEOUT=4:
  - READ with bus_ack never asserted: bus_req high for exactly 4 cycles, then status 1 with data 0.
  - Repeat with bus_ack on cycle 4: status 0.
  - Send a stray bus_ack in IDLE: no effect.
- Run:
  - RUN N=5: run_en high for exactly 5 cycles, then rsp_data=5.
  - RUN N=0: no run_en, rsp_valid at A+1 with data 0.
- Back-to-back: issue 20 random commands with rsp_ready always high. Each response carries the matching tag in order, with no lost or duplicated responses.
